// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU.
// Ports: clk, rst_n (async low), instr, is_zero, mem_ready in; pc, ir,
//   regwrite, reg_dest, aluop, memtoreg, mem_req, memwrite, halted, err,
//   state out.
module seq_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        is_zero,
    input  logic        mem_ready,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        regwrite,
    output logic        reg_dest,
    output logic        aluop,
    output logic        memtoreg,
    output logic        mem_req,
    output logic        memwrite,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;
    localparam logic [2:0] OP_NOP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Counter value seen on the last MEM cycle allowed before faulting.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  opcode;
    logic [15:0] pc_inc;
    logic [15:0] br_off;
    logic [7:0]  wait_cnt;
    logic [2:0]  next_state;
    logic [15:0] next_pc;
    logic        set_err;
    logic        imm_op;

    assign opcode = ir[15:13];
    assign pc_inc = pc + 16'd1;
    assign br_off = {{9{ir[6]}}, ir[6:0]};
    assign imm_op = (opcode == OP_ADDI) || (opcode == OP_LW) ||
                    (opcode == OP_SW);

    always_comb begin
        next_state = state;
        next_pc    = pc;
        set_err    = 1'b0;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_J: begin
                        next_pc    = {pc[15:13], ir[12:0]};
                        next_state = S_FETCH;
                    end
                    OP_NOP: begin
                        next_pc    = pc_inc;
                        next_state = S_FETCH;
                    end
                    OP_HALT: next_state = S_HALT;
                    default: next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_ADDI: next_state = S_WB;
                    OP_LW, OP_SW:  next_state = S_MEM;
                    OP_BEQ: begin
                        next_pc    = is_zero ? pc_inc + br_off : pc_inc;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        next_pc    = pc_inc;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_HALT;
                    set_err    = 1'b1;
                end
            end
            S_WB: begin
                next_pc    = pc_inc;
                next_state = S_FETCH;
            end
            S_HALT: next_state = S_HALT;
            default: begin
                next_state = S_HALT;
                set_err    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            err   <= err | set_err;
            if (state == S_FETCH) begin
                ir <= instr;
            end
            // Held at zero outside MEM so every MEM entry starts from 0.
            if (state != S_MEM) begin
                wait_cnt <= 8'd0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        regwrite = 1'b0;
        reg_dest = 1'b0;
        aluop    = 1'b0;
        memtoreg = 1'b0;
        mem_req  = 1'b0;
        memwrite = 1'b0;
        case (state)
            S_EXEC: aluop = imm_op;
            S_MEM: begin
                mem_req  = 1'b1;
                aluop    = 1'b1;
                memwrite = (opcode == OP_SW);
            end
            S_WB: begin
                regwrite = 1'b1;
                reg_dest = (opcode == OP_R);
                memtoreg = (opcode == OP_LW);
                aluop    = imm_op;
            end
            default: ;
        endcase
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed bench for seq_ctrl with hand-computed expectations.
// Two instances: RESET_PC 16'h0010 for the main flow, 16'hE001 for jumps/wrap.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [15:0] instr, instr2;
    logic        is_zero, mem_ready;

    logic [15:0] pc, ir, pc2, ir2;
    logic        regwrite, reg_dest, aluop, memtoreg;
    logic        mem_req, memwrite, halted, err;
    logic [2:0]  state, state2;
    logic        regwrite2, reg_dest2, aluop2, memtoreg2;
    logic        mem_req2, memwrite2, halted2, err2;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0] sa, sa2;
    assign sa  = {regwrite, reg_dest, aluop, memtoreg, mem_req, memwrite};
    assign sa2 = {regwrite2, reg_dest2, aluop2, memtoreg2,
                  mem_req2, memwrite2};

    always #5 clk = ~clk;

    seq_ctrl #(.RESET_PC(16'h0010), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .is_zero(is_zero),
        .mem_ready(mem_ready), .pc(pc), .ir(ir), .regwrite(regwrite),
        .reg_dest(reg_dest), .aluop(aluop), .memtoreg(memtoreg),
        .mem_req(mem_req), .memwrite(memwrite), .halted(halted),
        .err(err), .state(state)
    );

    seq_ctrl #(.RESET_PC(16'hE001), .MEM_TIMEOUT(15)) dut2 (
        .clk(clk), .rst_n(rst2_n), .instr(instr2), .is_zero(1'b0),
        .mem_ready(1'b0), .pc(pc2), .ir(ir2), .regwrite(regwrite2),
        .reg_dest(reg_dest2), .aluop(aluop2), .memtoreg(memtoreg2),
        .mem_req(mem_req2), .memwrite(memwrite2), .halted(halted2),
        .err(err2), .state(state2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Check state and strobes for the current cycle, then advance one.
    task automatic cyc(input string tag, input logic [2:0] st,
                       input logic [5:0] sb);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_strobes"}, 32'(sa), 32'(sb));
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        instr = 16'h0; instr2 = 16'h0;
        is_zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0010);
        check("rst_state", 32'(state), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_strobes", 32'(sa), 0);
        check("rst_flags", 32'({halted, err}), 0);
        check("rst2_pc", 32'(pc2), 32'hE001);
        rst_n = 1'b1;

        instr = 16'hA000;
        step(2);
        check("j0_pc", 32'(pc), 0);

        instr = 16'h0530;
        cyc("r_f", 3'd0, 6'b000000);
        cyc("r_d", 3'd1, 6'b000000);
        cyc("r_e", 3'd2, 6'b000000);
        cyc("r_w", 3'd4, 6'b110000);
        check("r_pc", 32'(pc), 1);
        instr = 16'h2505;
        cyc("a_f", 3'd0, 6'b000000);
        cyc("a_d", 3'd1, 6'b000000);
        cyc("a_e", 3'd2, 6'b001000);
        cyc("a_w", 3'd4, 6'b101000);
        check("a_pc", 32'(pc), 2);
        check("a_state", 32'(state), 0);

        instr = 16'h4283;
        mem_ready = 1'b1;
        cyc("lw_f", 3'd0, 6'b000000);
        cyc("lw_d", 3'd1, 6'b000000);
        cyc("lw_e", 3'd2, 6'b001000);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_mw", 3'd3, 6'b001010);
        mem_ready = 1'b1;
        cyc("lw_mr", 3'd3, 6'b001010);
        mem_ready = 1'b0;
        cyc("lw_w", 3'd4, 6'b101100);
        check("lw_pc", 32'(pc), 3);
        check("lw_after", 32'({state, sa}), 0);

        instr = 16'hA005;
        step(2);
        check("j5_pc", 32'(pc), 5);
        instr = 16'h807E;
        is_zero = 1'b1;
        cyc("beq_f", 3'd0, 6'b000000);
        cyc("beq_d", 3'd1, 6'b000000);
        check("beq_pc_mid", 32'(pc), 5);
        cyc("beq_e", 3'd2, 6'b000000);
        check("beq_taken_pc", 32'(pc), 4);
        check("beq_taken_st", 32'(state), 0);
        instr = 16'hA005;
        step(2);
        instr = 16'h807E;
        is_zero = 1'b0;
        step(3);
        check("beq_nt_pc", 32'(pc), 6);

        instr = 16'h6283;
        mem_ready = 1'b0;
        cyc("sw_f", 3'd0, 6'b000000);
        cyc("sw_d", 3'd1, 6'b000000);
        cyc("sw_e", 3'd2, 6'b001000);
        for (int i = 0; i < 15; i++) cyc("sw_m", 3'd3, 6'b001011);
        check("to_state", 32'(state), 5);
        check("to_flags", 32'({halted, err}), 32'h3);
        check("to_pc", 32'(pc), 6);
        check("to_strobes", 32'(sa), 0);
        mem_ready = 1'b1;
        step(3);
        check("to_hold", 32'({state, halted, err, sa}), 32'({3'd5, 2'b11, 6'd0}));
        check("to_hold_pc", 32'(pc), 6);

        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", 32'(pc), 32'h0010);
        check("arst_st", 32'(state), 0);
        check("arst_flags", 32'({halted, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;

        instr = 16'hA000;
        step(2);
        instr = 16'h4283;
        step(3);
        check("mrst_pre", 32'({state, mem_req}), 32'({3'd3, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("mrst_strobes", 32'(sa), 0);
        check("mrst_state", 32'(state), 0);
        check("mrst_pc", 32'(pc), 32'h0010);
        check("mrst_ir", 32'(ir), 0);
        @(negedge clk);
        rst_n = 1'b1;

        rst2_n = 1'b1;
        instr2 = 16'hAABC;
        step(1);
        check("j2_mid_pc", 32'(pc2), 32'hE001);
        check("j2_mid_st", 32'(state2), 1);
        step(1);
        check("j2_pc", 32'(pc2), 32'hEABC);
        instr2 = 16'hBFFF;
        step(2);
        check("jff_pc", 32'(pc2), 32'hFFFF);
        instr2 = 16'hC000;
        step(2);
        check("nop_wrap_pc", 32'(pc2), 0);
        instr2 = 16'hE000;
        step(2);
        check("hlt_state", 32'(state2), 5);
        check("hlt_flags", 32'({halted2, err2}), 32'h2);
        check("hlt_strobes", 32'(sa2), 0);
        step(4);
        check("hlt_hold", 32'({state2, halted2}), 32'({3'd5, 1'b1}));
        check("hlt_pc", 32'(pc2), 0);
        #2 rst2_n = 1'b0;
        #1;
        check("hlt_rst", 32'({state2, halted2}), 0);
        check("hlt_rst_pc", 32'(pc2), 32'hE001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the 16-bit CPU datapath. It owns the program counter and instruction register and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the register-file, ALU-mux, data-memory and write-back-mux strobes. This lets one ALU and one data-memory port be reused across cycles, and lets data memory take a variable number of cycles via a ready handshake.

## Interface
- RESET_PC, 16'h0000: PC value loaded on reset.
- MEM_TIMEOUT, 15: maximum cycles MEM waits for `mem_ready` before faulting (1..255).

- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  16  instruction word from instruction memory at address `pc`.
- is_zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory has completed the current access.
- pc  out  16  program counter to instruction memory.
- ir  out  16  latched instruction. Fields: opcode[15:13], rs[12:10], rt[9:7], rd[6:4], func[3:0], imm7[6:0], jaddr[12:0].
- regwrite  out  1  register-file write enable.
- reg_dest  out  1  1 = write `rd`, 0 = write `rt`.
- aluop  out  1  1 = ALU B operand is immediate, 0 = `read2`.
- memtoreg  out  1  1 = write-back data comes from memory.
- mem_req  out  1  data-memory access request.
- memwrite  out  1  data-memory write (qualified by `mem_req`).
- halted  out  1  sequencer stopped.
- err  out  1  memory timeout fault (sticky).
- state  out  3  current state, for debug.

## Operation
- Opcode map: 000 R-type (ALU function from func), 001 addi, 010 lw, 011 sw, 100 beq, 101 j, 110 nop, 111 halt.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to HALT with `err` set.
- FETCH: `ir <= instr`. Next state DECODE.
- DECODE, by opcode:
  - j: `pc <= {pc[15:13], jaddr}`, next FETCH.
  - nop: `pc <= pc+1`, next FETCH.
  - halt: next HALT.
  - all others: next EXEC.
- EXEC: `aluop`=1 for addi/lw/sw, 0 for R-type/beq.
  - R-type/addi: next WB.
  - lw/sw: next MEM.
  - beq: if `is_zero`, `pc <= pc + 1 + sext(imm7)`, else `pc <= pc+1`. Next FETCH.
- MEM: `mem_req`=1, `aluop`=1, `memwrite`=1 for sw only. The wait counter increments each cycle `mem_ready`=0.
  - On `mem_ready`=1, sw: `pc <= pc+1`, next FETCH.
  - On `mem_ready`=1, lw: next WB.
  - If the counter reaches MEM_TIMEOUT with no ready: next HALT, `err <= 1`. PC unchanged.
- WB: `regwrite`=1 for exactly one cycle.
  - `reg_dest`=1 only for R-type.
  - `memtoreg`=1 only for lw.
  - `aluop` as in EXEC.
  - `pc <= pc+1`, next FETCH.
- HALT: absorbing state. `halted`=1, all strobes 0. Only reset exits.
- Arithmetic: PC is 16-bit modulo (16'hFFFF+1 = 16'h0000). sext(imm7) replicates bit 6 into bits 15:7. A branch offset of 7'h7F gives `pc+1-1 = pc`, i.e. a self-loop.
- Strobe outputs are decoded combinationally from `state` and `ir` only (Moore). No output depends directly on `mem_ready`, `instr` or `is_zero`.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clock edge):
  - `state`=FETCH, `pc`=RESET_PC, `ir`=0, wait counter 0, `err`=0, `halted`=0.
  - All strobes 0.
  - Reset mid-MEM drops `mem_req` immediately, without waiting for the clock.
- Cycles per instruction:
  - j / nop: 2.
  - beq: 3.
  - R-type / addi: 4.
  - sw: 4 + W.
  - lw: 5 + W, where W is the number of cycles `mem_ready` stays low.
- `mem_ready` is sampled only in MEM. `mem_ready`=1 in the first MEM cycle gives W=0. `mem_ready` asserted in any other state is ignored.
- `mem_req` and `memwrite` hold stable for the whole of MEM and are both 0 on the cycle after MEM is left.
- The wait counter clears on MEM entry.
- `pc` changes only on the clock edge that leaves DECODE, EXEC, MEM or WB. `instr` must be valid at the FETCH edge.

## Test plan
- Reset: RESET_PC=16'h0010, pulse `rst_n` low asynchronously mid-cycle → `pc`=16'h0010, `state`=0, every strobe 0 before the next edge.
- R-type then addi at PC 0,1 → each takes 4 cycles. `regwrite` is high only in WB, `reg_dest` is 1 then 0, `aluop` is 0 then 1. PC reads 2 at cycle 8.
- lw with `mem_ready` held low 3 cycles → `mem_req` high for 4 cycles, `memwrite` 0, then WB with `memtoreg`=1. Total 8 cycles.
- sw with `mem_ready` never asserted, MEM_TIMEOUT=15 → HALT after 15 MEM cycles, `err`=1, `halted`=1, PC unchanged, strobes 0 from then on.
- beq at PC 16'h0005, imm7=7'h7E, `is_zero`=1 → PC=16'h0004 after 3 cycles. Repeat with `is_zero`=0 → PC=16'h0006.
- j at PC 16'hE001, jaddr=13'h0ABC → PC=16'hEABC after 2 cycles. nop at 16'hFFFF → PC wraps to 16'h0000. halt opcode → `halted`=1 and holds until `rst_n` low.
